// File: rtl/game_pkg.sv
// Shared types and constants for the penalty-shootout controller.
// Screen encoding is consumed by the draw_screen_* mux upstream of draw_mouse.
package game_pkg;

  typedef enum logic [2:0] {
    SCR_START,
    SCR_SHOOTER,
    SCR_KEEPER,
    SCR_RESULT,
    SCR_WINNER,
    SCR_LOSER
  } screen_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/game_ctrl_lfsr16.sv
// Free-running 16-bit maximal-length LFSR; supplies the simulated opponent's kicks.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] out
);

  always_ff @(posedge clk) begin
    if (rst) out <= SEED;
    else     out <= lfsr_step(out);
  end

endmodule

// File: rtl/game_ctrl.sv
// Penalty-shootout controller: turn FSM, score/kick counters, regulation and
// sudden-death decisions, and the registered screen select.
module game_ctrl
  import game_pkg::*;
#(
  parameter int ROUNDS      = 5,
  parameter int SCORE_W     = 4,
  parameter int HOLD_CYCLES = 65000000,
  parameter int SOLO_PCT_W  = 8,
  parameter int SOLO_THR    = 192
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               solo_enable,
  input  logic               left_clicked,
  input  logic               kick_done,
  input  logic               is_scored,
  output logic [2:0]         screen,
  output logic [SCORE_W-1:0] score_player,
  output logic [SCORE_W-1:0] score_opp,
  output logic [3:0]         kick_idx,
  output logic               sudden_death,
  output logic               last_scored
);

  localparam int DW = SCORE_W + 2;
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0]      HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  screen_t       scr_q;
  logic          lc_q;
  logic          solo_q;
  logic          last_keeper;
  logic [TW-1:0] timer;
  logic [15:0]   rnd;
  logic          unused_rnd;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (rnd)
  );

  assign unused_rnd = ^rnd;
  assign screen     = scr_q;

  logic click;
  assign click = left_clicked & ~lc_q;

  // In solo mode the keeper turn resolves itself from the LFSR; a stray
  // kick_done is irrelevant there.
  logic solo_goal, keeper_fire, keeper_goal;
  assign solo_goal   = rnd[SOLO_PCT_W-1:0] < SOLO_PCT_W'(SOLO_THR);
  assign keeper_fire = solo_q | kick_done;
  assign keeper_goal = solo_q ? solo_goal : is_scored;

  // Decision after the kick just shown on RESULT. kick_idx is the current pair,
  // so the player has always taken kick_idx+1 kicks and the opponent the same
  // only once the keeper half of the pair is done.
  logic [DW-1:0] p_w, o_w, kp_w, ko_w, left_p, left_o;
  logic          dec_win, dec_lose, dec_tie_end;

  always_comb begin
    p_w         = DW'(score_player);
    o_w         = DW'(score_opp);
    kp_w        = DW'(kick_idx) + DW'(1);
    ko_w        = DW'(kick_idx) + DW'(last_keeper);
    left_p      = DW'(ROUNDS) - kp_w;
    left_o      = DW'(ROUNDS) - ko_w;
    dec_win     = 1'b0;
    dec_lose    = 1'b0;
    dec_tie_end = 1'b0;
    if (!sudden_death) begin
      dec_win     = p_w > (o_w + left_o);
      dec_lose    = !dec_win && (o_w > (p_w + left_p));
      dec_tie_end = !dec_win && !dec_lose && last_keeper && (kp_w == DW'(ROUNDS));
    end else if (last_keeper) begin
      dec_win  = p_w > o_w;
      dec_lose = p_w < o_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scr_q        <= SCR_START;
      lc_q         <= 1'b0;
      solo_q       <= 1'b0;
      last_keeper  <= 1'b0;
      timer        <= '0;
      score_player <= '0;
      score_opp    <= '0;
      kick_idx     <= '0;
      sudden_death <= 1'b0;
      last_scored  <= 1'b0;
    end else begin
      lc_q <= left_clicked;
      case (scr_q)
        SCR_START: begin
          if (click) begin
            scr_q        <= SCR_SHOOTER;
            solo_q       <= solo_enable;
            score_player <= '0;
            score_opp    <= '0;
            kick_idx     <= '0;
            sudden_death <= 1'b0;
          end
        end
        SCR_SHOOTER: begin
          if (kick_done) begin
            last_scored <= is_scored;
            last_keeper <= 1'b0;
            timer       <= HOLD_LOAD;
            scr_q       <= SCR_RESULT;
            if (is_scored && score_player != SCORE_MAX)
              score_player <= score_player + 1'b1;
          end
        end
        SCR_KEEPER: begin
          if (keeper_fire) begin
            last_scored <= keeper_goal;
            last_keeper <= 1'b1;
            timer       <= HOLD_LOAD;
            scr_q       <= SCR_RESULT;
            if (keeper_goal && score_opp != SCORE_MAX)
              score_opp <= score_opp + 1'b1;
          end
        end
        SCR_RESULT: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (dec_win) begin
            scr_q <= SCR_WINNER;
          end else if (dec_lose) begin
            scr_q <= SCR_LOSER;
          end else begin
            if (dec_tie_end) sudden_death <= 1'b1;
            if (last_keeper) begin
              scr_q <= SCR_SHOOTER;
              if (kick_idx != 4'd15) kick_idx <= kick_idx + 4'd1;
            end else begin
              scr_q <= SCR_KEEPER;
            end
          end
        end
        SCR_WINNER, SCR_LOSER: begin
          if (click) scr_q <= SCR_START;
        end
        default: scr_q <= SCR_START;
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed + randomized bench for game_ctrl against a kick-count reference model.
module tb_game_ctrl;
  import game_pkg::*;

  localparam int R    = 5;
  localparam int SW   = 4;
  localparam int HOLD = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, solo_enable, left_clicked, kick_done, is_scored;
  logic [2:0]    screen;
  logic [SW-1:0] score_player, score_opp;
  logic [3:0]    kick_idx;
  logic          sudden_death, last_scored;

  logic       solo_b, lc_b, kd_b, is_b;
  logic [2:0] screen_b;
  logic [1:0] sp_b, so_b;
  logic [3:0] kidx_b;
  logic       sd_b, last_b;

  game_ctrl #(.ROUNDS(R), .SCORE_W(SW), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .solo_enable(solo_enable), .left_clicked(left_clicked),
    .kick_done(kick_done), .is_scored(is_scored), .screen(screen),
    .score_player(score_player), .score_opp(score_opp), .kick_idx(kick_idx),
    .sudden_death(sudden_death), .last_scored(last_scored)
  );

  game_ctrl #(.ROUNDS(15), .SCORE_W(2), .HOLD_CYCLES(1)) dut_sat (
    .clk(clk), .rst(rst), .solo_enable(solo_b), .left_clicked(lc_b),
    .kick_done(kd_b), .is_scored(is_b), .screen(screen_b),
    .score_player(sp_b), .score_opp(so_b), .kick_idx(kidx_b),
    .sudden_death(sd_b), .last_scored(last_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference LFSR: feedback is the parity of the tap positions 16/14/13/11.
  logic [15:0] lf;
  always @(posedge clk) begin
    if (rst) lf <= 16'hACE1;
    else     lf <= {lf[14:0], ^(lf & 16'hB400)};
  end

  // Game model: goals and kicks per side, pair index, sudden-death flag.
  int mp, mo, np, no, kidx, mend;
  bit msd, m_shoot, m_solo;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_screen", screen, SCR_START);
    chk("rst_sp", score_player, 0);
    chk("rst_so", score_opp, 0);
    chk("rst_kidx", kick_idx, 0);
    chk("rst_sd", sudden_death, 0);
    chk("rst_last", last_scored, 0);
  endtask

  task automatic chk_model();
    chk("score_player", score_player, mp);
    chk("score_opp", score_opp, mo);
    chk("kick_idx", kick_idx, kidx);
    chk("sudden_death", sudden_death, msd);
  endtask

  function automatic int exp_screen();
    if (mend == 1) return SCR_WINNER;
    if (mend == 2) return SCR_LOSER;
    return m_shoot ? SCR_SHOOTER : SCR_KEEPER;
  endfunction

  // Apply the shootout rules to the tallies after the kick just taken.
  function automatic void decide();
    bit kept = !m_shoot;
    mend = 0;
    if (!msd) begin
      if (mp > mo + (R - no))      mend = 1;
      else if (mo > mp + (R - np)) mend = 2;
      else if (np == R && no == R) msd = 1;
    end else if (np == no) begin
      if (mp > mo)      mend = 1;
      else if (mp < mo) mend = 2;
    end
    if (mend == 0) begin
      if (kept) kidx = (kidx < 15) ? kidx + 1 : 15;
      m_shoot = !m_shoot;
    end
  endfunction

  task automatic click();
    left_clicked = 1'b1;
    step();
    left_clicked = 1'b0;
    step();
  endtask

  task automatic start_game(input bit s);
    if (screen != SCR_START) begin
      click();
      chk("back_to_start", screen, SCR_START);
    end
    solo_enable = s;
    click();
    solo_enable = 1'b0;
    mp = 0; mo = 0; np = 0; no = 0; kidx = 0; mend = 0;
    msd = 1'b0; m_shoot = 1'b1; m_solo = s;
    chk("start_screen", screen, SCR_SHOOTER);
    chk_model();
  endtask

  // g: 0/1 forced outcome, -1 random. poke: inject ignored click/kick_done.
  task automatic play_turn(input int g, input bit poke);
    bit goal;
    int cyc;
    chk("turn_screen", screen, m_shoot ? SCR_SHOOTER : SCR_KEEPER);
    if (poke && m_shoot) begin
      left_clicked = 1'b1;
      step();
      left_clicked = 1'b0;
      chk("click_in_shooter", screen, SCR_SHOOTER);
    end
    if (!m_shoot && m_solo) begin
      goal = (lf[7:0] < 8'd192);
      step();
    end else begin
      goal = (g < 0) ? bit'($urandom_range(0, 1)) : g[0];
      kick_done = 1'b1;
      is_scored = goal;
      step();
      kick_done = 1'b0;
      is_scored = 1'b0;
    end
    if (m_shoot) begin
      np++;
      if (goal && mp < SMAX) mp++;
    end else begin
      no++;
      if (goal && mo < SMAX) mo++;
    end
    chk("result_screen", screen, SCR_RESULT);
    chk("last_scored", last_scored, goal);
    chk("result_sp", score_player, mp);
    chk("result_so", score_opp, mo);
    cyc = 0;
    while (screen == SCR_RESULT && cyc < 4 * HOLD) begin
      if (poke && cyc == 0) begin
        kick_done = 1'b1;
        is_scored = 1'b1;
        left_clicked = 1'b1;
      end
      step();
      kick_done = 1'b0;
      is_scored = 1'b0;
      left_clicked = 1'b0;
      cyc++;
    end
    chk("hold_cycles", cyc, HOLD);
    decide();
    chk("next_screen", screen, exp_screen());
    chk_model();
  endtask

  task automatic play_to_end();
    int turns = 0;
    while (mend == 0 && turns < 200) begin
      play_turn(-1, 1'b0);
      turns++;
    end
    chk("game_ended", (mend != 0), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; solo_enable = 1'b0; left_clicked = 1'b0; kick_done = 1'b0; is_scored = 1'b0;
    solo_b = 1'b0; lc_b = 1'b0; kd_b = 1'b0; is_b = 1'b0;
    mend = 0; m_shoot = 1'b1; m_solo = 1'b0; msd = 1'b0;
    step(); step();
    chk_reset_state();
    chk("rst_screen_b", screen_b, SCR_START);
    rst = 1'b0;
    step();

    // Early win: player 3/3, opponent 0/3, with ignored click/kick_done on turn 1.
    start_game(1'b0);
    play_turn(1, 1'b1);
    play_turn(0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      play_turn(1, 1'b0);
      play_turn(0, 1'b0);
    end
    chk("early_win", screen, SCR_WINNER);
    chk("early_sp", score_player, 3);
    chk("early_so", score_opp, 0);

    // Held button: exactly one click.
    left_clicked = 1'b1;
    step();
    chk("held_click_1", screen, SCR_START);
    repeat (3) step();
    chk("held_click_n", screen, SCR_START);
    left_clicked = 1'b0;
    step();

    // 4-4 regulation, sudden death goal/miss.
    start_game(1'b0);
    for (int i = 0; i < 4; i++) begin
      play_turn(1, 1'b0);
      play_turn(1, 1'b0);
    end
    play_turn(0, 1'b0);
    play_turn(0, 1'b0);
    chk("sd_set", sudden_death, 1);
    play_turn(1, 1'b0);
    play_turn(0, 1'b0);
    chk("sd_win", screen, SCR_WINNER);
    chk("sd_sp", score_player, 5);
    chk("sd_so", score_opp, 4);
    chk("sd_kidx", kick_idx, 5);

    // Randomized games, both modes.
    for (int gnum = 0; gnum < 8; gnum++) begin
      start_game(gnum[0]);
      play_to_end();
    end

    // Reset mid-RESULT with the hold timer counting.
    start_game(1'b0);
    kick_done = 1'b1; is_scored = 1'b1;
    step();
    kick_done = 1'b0; is_scored = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk_reset_state();
    rst = 1'b0;
    step();

    // Reset while in KEEPER.
    start_game(1'b0);
    play_turn(1, 1'b0);
    chk("pre_rst_keeper", screen, SCR_KEEPER);
    rst = 1'b1;
    step();
    chk_reset_state();
    rst = 1'b0;
    step();

    // SCORE_W=2 instance: both sides keep scoring, counters saturate at 3.
    lc_b = 1'b1;
    step();
    lc_b = 1'b0;
    step();
    chk("sat_start", screen_b, SCR_SHOOTER);
    for (int k = 1; k <= 5; k++) begin
      kd_b = 1'b1; is_b = 1'b1;
      step();
      kd_b = 1'b0;
      chk("sat_player", sp_b, (k > 3) ? 3 : k);
      step();
      chk("sat_keeper_turn", screen_b, SCR_KEEPER);
      kd_b = 1'b1;
      step();
      kd_b = 1'b0;
      chk("sat_opp", so_b, (k > 3) ? 3 : k);
      step();
      chk("sat_shooter_turn", screen_b, SCR_SHOOTER);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
